present_enc_sched: RTL and testbench

- Multi-requester scheduler for the single iterative PRESENT-80 encryption core; the core itself is instantiated by the parent.
- Arbitrates NREQ plaintext/key requests round-robin and drives the core's load strobe and data/key inputs.
- Counts the 31 core rounds and captures the ciphertext into a response register.
- Returns the ciphertext with the winning requester's ID over a valid/ready response channel.

---
 rtl/present_enc_pkg.sv | 21 ++
 rtl/present_rr_arbiter.sv | 37 +++
 rtl/present_enc_sched.sv | 181 ++++++++++++++++++
 tb/tb_present_enc_sched.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/present_enc_pkg.sv
// Shared definitions for the PRESENT-80 encryption scheduler:
// FSM state encoding, round count and datapath widths.
package present_enc_pkg;

    localparam int PRESENT_ROUNDS = 31;
    localparam int PRESENT_DW     = 64;
    localparam int PRESENT_KW     = 80;

    // Round counter only has to reach PRESENT_ROUNDS-1.
    localparam int RCNT_W = $clog2(PRESENT_ROUNDS);
    localparam logic [RCNT_W-1:0] RCNT_LAST = RCNT_W'(PRESENT_ROUNDS - 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LOAD    = 3'd1,
        RUN     = 3'd2,
        CAPTURE = 3'd3,
        DONE    = 3'd4
    } sched_state_e;

endpackage

// File: rtl/present_rr_arbiter.sv
// Round-robin arbiter: grants the first asserted request at or above ptr,
// wrapping at NREQ. Purely combinational; the pointer lives in the parent.
module present_rr_arbiter #(
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    input  logic            en,
    output logic [NREQ-1:0] gnt,
    output logic [IDW-1:0]  gnt_idx
);

    logic [IDW:0] cand;
    logic         found;

    // Search upward from ptr; wrap is done by explicit subtraction of NREQ
    // so a non-power-of-two NREQ never aliases through IDW overflow.
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        cand    = '0;
        for (int k = 0; k < NREQ; k++) begin
            cand = {1'b0, ptr} + (IDW+1)'(k);
            if (cand >= (IDW+1)'(NREQ)) begin
                cand = cand - (IDW+1)'(NREQ);
            end
            if (en && !found && req[cand[IDW-1:0]]) begin
                found                = 1'b1;
                gnt[cand[IDW-1:0]]   = 1'b1;
                gnt_idx              = cand[IDW-1:0];
            end
        end
    end

endmodule

// File: rtl/present_enc_sched.sv
// Scheduler in front of one iterative PRESENT-80 core (core lives in the parent).
// Picks a requester round-robin, loads the core, counts 31 rounds, captures the
// ciphertext and returns it with the requester ID.
// Optional statistics counters (op_count, stall_count) are built when the
// macro PRESENT_ENC_SCHED_STATS_EN is defined.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are both
// high. req_ready depends combinationally on req_valid (only in IDLE); rsp_valid
// never depends on rsp_ready, and rsp_ct/rsp_id stay fixed while rsp_valid waits.
module present_enc_sched
    import present_enc_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NREQ-1:0]            req_valid,
    output logic [NREQ-1:0]            req_ready,
    input  logic [PRESENT_DW*NREQ-1:0] req_pt,
    input  logic [PRESENT_KW*NREQ-1:0] req_key,
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic [PRESENT_DW-1:0]      rsp_ct,
    output logic [IDW-1:0]             rsp_id,
    output logic                       core_load,
    output logic [PRESENT_DW-1:0]      core_idat,
    output logic [PRESENT_KW-1:0]      core_key,
    input  logic [PRESENT_DW-1:0]      core_odat
`ifdef PRESENT_ENC_SCHED_STATS_EN
    ,
    output logic [15:0]                op_count,
    output logic [15:0]                stall_count
`endif
);

    sched_state_e          state_q, state_d;
    logic [IDW-1:0]        ptr_q, ptr_d;
    logic [RCNT_W-1:0]     rcnt_q, rcnt_d;
    logic [PRESENT_DW-1:0] hold_pt_q, hold_pt_d;
    logic [PRESENT_KW-1:0] hold_key_q, hold_key_d;
    logic [IDW-1:0]        hold_id_q, hold_id_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic [PRESENT_DW-1:0] rsp_ct_q, rsp_ct_d;
    logic [IDW-1:0]        rsp_id_q, rsp_id_d;

    logic                  arb_en;
    logic [NREQ-1:0]       gnt;
    logic [IDW-1:0]        gnt_idx;

    // Grants only in IDLE; held off while reset is asserted so no ready leaks out.
    assign arb_en = (state_q == IDLE) && rst_n;

    present_rr_arbiter #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_arb (
        .req     (req_valid),
        .ptr     (ptr_q),
        .en      (arb_en),
        .gnt     (gnt),
        .gnt_idx (gnt_idx)
    );

    assign req_ready = gnt;
    assign rsp_valid = rsp_valid_q;
    assign rsp_ct    = rsp_ct_q;
    assign rsp_id    = rsp_id_q;
    assign core_load = (state_q == LOAD);
    assign core_idat = hold_pt_q;
    assign core_key  = hold_key_q;

    // Next-state and datapath updates for the job FSM.
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        rcnt_d      = rcnt_q;
        hold_pt_d   = hold_pt_q;
        hold_key_d  = hold_key_q;
        hold_id_d   = hold_id_q;
        rsp_valid_d = rsp_valid_q;
        rsp_ct_d    = rsp_ct_q;
        rsp_id_d    = rsp_id_q;
        case (state_q)
            IDLE: begin
                if (|gnt) begin
                    for (int r = 0; r < NREQ; r++) begin
                        if (gnt[r]) begin
                            hold_pt_d  = req_pt[r*PRESENT_DW +: PRESENT_DW];
                            hold_key_d = req_key[r*PRESENT_KW +: PRESENT_KW];
                        end
                    end
                    hold_id_d = gnt_idx;
                    ptr_d     = (gnt_idx == IDW'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
                    state_d   = LOAD;
                end
            end
            LOAD: begin
                rcnt_d  = '0;
                state_d = RUN;
            end
            RUN: begin
                rcnt_d = rcnt_q + 1'b1;
                if (rcnt_q == RCNT_LAST) begin
                    state_d = CAPTURE;
                end
            end
            CAPTURE: begin
                rsp_ct_d    = core_odat;
                rsp_id_d    = hold_id_q;
                rsp_valid_d = 1'b1;
                state_d     = DONE;
            end
            DONE: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset drops any job in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            rcnt_q      <= '0;
            hold_pt_q   <= '0;
            hold_key_q  <= '0;
            hold_id_q   <= '0;
            rsp_valid_q <= 1'b0;
            rsp_ct_q    <= '0;
            rsp_id_q    <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            rcnt_q      <= rcnt_d;
            hold_pt_q   <= hold_pt_d;
            hold_key_q  <= hold_key_d;
            hold_id_q   <= hold_id_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_ct_q    <= rsp_ct_d;
            rsp_id_q    <= rsp_id_d;
        end
    end

`ifdef PRESENT_ENC_SCHED_STATS_EN
    logic [15:0] op_count_q, op_count_d;
    logic [15:0] stall_count_q, stall_count_d;

    assign op_count    = op_count_q;
    assign stall_count = stall_count_q;

    // Saturating counts of delivered responses and back-pressured DONE cycles.
    always_comb begin
        op_count_d    = op_count_q;
        stall_count_d = stall_count_q;
        if (state_q == DONE) begin
            if (rsp_ready) begin
                if (op_count_q != 16'hFFFF) op_count_d = op_count_q + 16'd1;
            end else begin
                if (stall_count_q != 16'hFFFF) stall_count_d = stall_count_q + 16'd1;
            end
        end
    end

    // Statistics registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_count_q    <= '0;
            stall_count_q <= '0;
        end else begin
            op_count_q    <= op_count_d;
            stall_count_q <= stall_count_d;
        end
    end
`endif

endmodule

// File: tb/tb_present_enc_sched.sv
// Directed bench for present_enc_sched with a behavioural PRESENT-80 core
// attached to the core_* ports. Expected ciphertexts are published vectors.
module tb_present_enc_sched;

    localparam int NREQ = 4;
    localparam int IDW  = 2;

    localparam logic [63:0] PT_0 = 64'h0;
    localparam logic [63:0] PT_F = 64'hFFFF_FFFF_FFFF_FFFF;
    localparam logic [79:0] K_0  = 80'h0;
    localparam logic [79:0] K_F  = 80'hFFFF_FFFF_FFFF_FFFF_FFFF;

    localparam logic [63:0] CT_P0_K0 = 64'h5579C1387B228445;
    localparam logic [63:0] CT_P0_KF = 64'hE72C46C0F5945049;
    localparam logic [63:0] CT_PF_K0 = 64'hA112FFC72F68417B;
    localparam logic [63:0] CT_PF_KF = 64'h3333DCD3213210D2;

    logic                 clk;
    logic                 rst_n;
    logic [NREQ-1:0]      req_valid;
    logic [NREQ-1:0]      req_ready;
    logic [64*NREQ-1:0]   req_pt;
    logic [80*NREQ-1:0]   req_key;
    logic                 rsp_valid;
    logic                 rsp_ready;
    logic [63:0]          rsp_ct;
    logic [IDW-1:0]       rsp_id;
    logic                 core_load;
    logic [63:0]          core_idat;
    logic [79:0]          core_key;
    logic [63:0]          core_odat;
`ifdef PRESENT_ENC_SCHED_STATS_EN
    logic [15:0]          op_count;
    logic [15:0]          stall_count;
`endif

    int n_checks = 0;
    int n_errors = 0;

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- DUT ----------------
    present_enc_sched #(.NREQ(NREQ)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_pt    (req_pt),
        .req_key   (req_key),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_ct    (rsp_ct),
        .rsp_id    (rsp_id),
        .core_load (core_load),
        .core_idat (core_idat),
        .core_key  (core_key),
        .core_odat (core_odat)
`ifdef PRESENT_ENC_SCHED_STATS_EN
        ,
        .op_count    (op_count),
        .stall_count (stall_count)
`endif
    );

    // ---------------- PRESENT-80 core model (no reset, no enable) ----------------
    function automatic logic [3:0] sbox(input logic [3:0] x);
        case (x)
            4'h0: sbox = 4'hC;  4'h1: sbox = 4'h5;  4'h2: sbox = 4'h6;  4'h3: sbox = 4'hB;
            4'h4: sbox = 4'h9;  4'h5: sbox = 4'h0;  4'h6: sbox = 4'hA;  4'h7: sbox = 4'hD;
            4'h8: sbox = 4'h3;  4'h9: sbox = 4'hE;  4'hA: sbox = 4'hF;  4'hB: sbox = 4'h8;
            4'hC: sbox = 4'h4;  4'hD: sbox = 4'h7;  4'hE: sbox = 4'h1;  default: sbox = 4'h2;
        endcase
    endfunction

    function automatic logic [63:0] sbox_layer(input logic [63:0] s);
        logic [63:0] o;
        for (int i = 0; i < 16; i++) o[4*i +: 4] = sbox(s[4*i +: 4]);
        return o;
    endfunction

    function automatic logic [63:0] p_layer(input logic [63:0] s);
        logic [63:0] o;
        o = '0;
        for (int i = 0; i < 63; i++) o[(16*i) % 63] = s[i];
        o[63] = s[63];
        return o;
    endfunction

    function automatic logic [79:0] key_upd(input logic [79:0] k, input logic [4:0] rc);
        logic [79:0] t;
        t          = {k[18:0], k[79:19]};
        t[79:76]   = sbox(t[79:76]);
        t[19:15]   = t[19:15] ^ rc;
        return t;
    endfunction

    logic [63:0] core_st = '0;
    logic [79:0] core_kr = '0;
    logic [4:0]  core_rc = 5'd1;

    always @(posedge clk) begin
        if (core_load) begin
            core_st <= core_idat;
            core_kr <= core_key;
            core_rc <= 5'd1;
        end else begin
            core_st <= p_layer(sbox_layer(core_st ^ core_kr[79:16]));
            core_kr <= key_upd(core_kr, core_rc);
            core_rc <= core_rc + 5'd1;
        end
    end

    assign core_odat = core_st ^ core_kr[79:16];

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [79:0] got, input logic [79:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_rsp_valid"}, 80'(rsp_valid), 80'(0));
        check({tag, "_rsp_ct"},    80'(rsp_ct),    80'(0));
        check({tag, "_rsp_id"},    80'(rsp_id),    80'(0));
        check({tag, "_core_load"}, 80'(core_load), 80'(0));
        check({tag, "_req_ready"}, 80'(req_ready), 80'(0));
        check({tag, "_core_idat"}, 80'(core_idat), 80'(0));
        check({tag, "_core_key"},  80'(core_key),  80'(0));
    endtask

    // ---------------- driver tasks ----------------
    task automatic do_reset();
        @(posedge clk); #1;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic set_req(input int r, input logic [63:0] pt, input logic [79:0] key);
        req_pt[r*64 +: 64]  = pt;
        req_key[r*80 +: 80] = key;
        req_valid[r]        = 1'b1;
        #1;
    endtask

    // Wait for the grant, follow the job through the core, then consume the
    // response after 'stall' cycles of rsp_ready low.
    task automatic serve(input int exp_id, input logic [63:0] exp_pt, input logic [79:0] exp_key,
                         input logic [63:0] exp_ct, input int stall, input bit drop);
        logic [NREQ-1:0] oh;
        int              w;
        int              lat;
        bit              stable;
        logic [63:0]     ct_seen;
        logic [IDW-1:0]  id_seen;
        oh         = '0;
        oh[exp_id] = 1'b1;
        w = 0;
        while (req_ready == '0 && w < 200) begin
            @(posedge clk); #1;
            w++;
        end
        check("grant", 80'(req_ready), 80'(oh));
        @(posedge clk); #1;
        if (drop) req_valid[exp_id] = 1'b0;
        check("core_load", 80'(core_load), 80'(1));
        check("core_idat", 80'(core_idat), 80'(exp_pt));
        check("core_key",  core_key,       exp_key);
        lat = 0;
        do begin
            @(posedge clk); #1;
            lat++;
            if (lat == 1) check("load_pulse", 80'(core_load), 80'(0));
        end while (!rsp_valid && lat < 100);
        check("latency",       80'(lat),       80'(33));
        check("rsp_ct",        80'(rsp_ct),    80'(exp_ct));
        check("rsp_id",        80'(rsp_id),    80'(exp_id));
        check("ready_in_done", 80'(req_ready), 80'(0));
        if (stall > 0) begin
            ct_seen = rsp_ct;
            id_seen = rsp_id;
            stable  = 1'b1;
            repeat (stall) begin
                @(posedge clk); #1;
                if (rsp_valid !== 1'b1 || rsp_ct !== ct_seen || rsp_id !== id_seen || req_ready !== '0)
                    stable = 1'b0;
            end
            check("stall_hold", 80'(stable), 80'(1));
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        check("rsp_once", 80'(rsp_valid), 80'(0));
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        bit quiet;
        rst_n     = 1'b1;
        req_valid = '0;
        req_pt    = '0;
        req_key   = '0;
        rsp_ready = 1'b0;
        #1 rst_n  = 1'b0;
        #1;
        check_all_zero("reset");
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        repeat (3) @(posedge clk);
        #1;
        check("idle_no_req", 80'(req_ready), 80'(0));
        check("idle_no_load", 80'(core_load), 80'(0));

        // single requesters
        set_req(0, PT_0, K_0);
        serve(0, PT_0, K_0, CT_P0_K0, 0, 1'b1);
        set_req(2, PT_0, K_F);
        serve(2, PT_0, K_F, CT_P0_KF, 0, 1'b1);

        // long response stall with another requester waiting (ptr is 3)
        set_req(3, PT_F, K_F);
        set_req(0, PT_F, K_0);
        serve(3, PT_F, K_F, CT_PF_KF, 100, 1'b1);
        serve(0, PT_F, K_0, CT_PF_K0, 0, 1'b1);

        // reset in the middle of RUN (ptr is 1, so requester 3 wins)
        set_req(3, PT_F, K_F);
        check("mid_grant", 80'(req_ready), 80'(4'b1000));
        @(posedge clk); #1;
        req_valid[3] = 1'b0;
        repeat (16) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check_all_zero("mid_reset");
        @(posedge clk); #1;
        rst_n = 1'b1;
        quiet = 1'b1;
        repeat (40) begin
            @(posedge clk); #1;
            if (rsp_valid !== 1'b0 || core_load !== 1'b0 || req_ready !== '0) quiet = 1'b0;
        end
        check("quiet_after_reset", 80'(quiet), 80'(1));
        set_req(0, PT_0, K_F);
        serve(0, PT_0, K_F, CT_P0_KF, 0, 1'b1);

        // all requesters continuously valid from a fresh reset
        do_reset();
`ifdef PRESENT_ENC_SCHED_STATS_EN
        check("op_count_reset",    80'(op_count),    80'(0));
        check("stall_count_reset", 80'(stall_count), 80'(0));
`endif
        set_req(0, PT_F, K_0);
        set_req(1, PT_F, K_F);
        set_req(2, PT_F, K_0);
        set_req(3, PT_F, K_F);
        serve(0, PT_F, K_0, CT_PF_K0, 0, 1'b0);
        serve(1, PT_F, K_F, CT_PF_KF, 5, 1'b0);
        serve(2, PT_F, K_0, CT_PF_K0, 0, 1'b0);
`ifdef PRESENT_ENC_SCHED_STATS_EN
        check("op_count_3",    80'(op_count),    80'(3));
        check("stall_count_5", 80'(stall_count), 80'(5));
`endif
        serve(3, PT_F, K_F, CT_PF_KF, 0, 1'b0);
        serve(0, PT_F, K_0, CT_PF_K0, 0, 1'b0);
`ifdef PRESENT_ENC_SCHED_STATS_EN
        check("op_count_5", 80'(op_count), 80'(5));
`endif
        req_valid = '0;
        repeat (2) @(posedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
